soc_mem_arbiter: RTL
====================

Name: soc_mem_arbiter

Overview:
- Parametrised shared-memory port for the SoC: N CPU-side masters (instruction fetch, data load/store, later DMA) share one synchronous memory.
- Replaces separate single-ported IMEM/DMEM hookup with one unified memory behind a round-robin arbiter.
- Memory read latency is configurable; requests are pipelined, one grant per cycle.
- Sits between core(s) and the memory macro inside the SoC top.

Parameters:
- N_MASTERS, 2, number of requesting masters (1..8); index 0 = instruction fetch.
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width; must be a multiple of 8.
- MEM_LAT, 1, cycles from mem_en to mem_rdata valid (1..4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- ena  input  1  system enable; 0 blocks new grants.
- req_valid  input  N_MASTERS  per-master request valid.
- req_ready  output  N_MASTERS  per-master grant, one-hot or zero; a request transfers when valid & ready.
- req_we  input  N_MASTERS  1 = write, 0 = read.
- req_addr  input  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  N_MASTERS*DATA_W  packed write data.
- req_be  input  N_MASTERS*DATA_W/8  packed byte enables; ignored for reads.
- rsp_valid  output  N_MASTERS  one-hot response strobe for the owning master.
- rsp_rdata  output  DATA_W  read data; shared by all masters, qualified by rsp_valid.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write.
- mem_be  output  DATA_W/8  memory byte enables.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid MEM_LAT cycles after a read mem_en.

Behaviour:
- Reset (reset=0 at clk edge):
  - req_ready, rsp_valid, mem_en, mem_we, mem_be = 0.
  - rsp_rdata, mem_addr, mem_wdata = 0.
  - Round-robin pointer = 0.
  - In-flight pipeline cleared; responses for requests accepted before reset are dropped, never emitted.
- Arbitration (combinational):
  - When ena=1, grant the first valid master at or after the pointer, searching upward with wrap.
  - req_ready is asserted only for the winner; req_ready does not depend on req_ready.
  - No valid request, or ena=0: req_ready = 0 and mem_en = 0.
- Memory issue:
  - Command is registered: mem_en/mem_we/mem_be/mem_addr/mem_wdata are driven from the winner in the cycle after the grant.
  - Read: mem_be = all-ones. Write: mem_be = req_be.
  - Throughput: one accepted request per cycle, back-to-back.
- Pointer update:
  - On a grant to master g, pointer <= (g+1) mod N_MASTERS.
  - Without a grant, the pointer holds.
- Response tracking:
  - Shift register of depth MEM_LAT carries {valid, owner id, is_write} for each issued command.
  - At the exit stage, rsp_valid = one-hot(owner) for both reads and writes; writes act as acks.
  - rsp_rdata = mem_rdata for reads; rsp_rdata holds its previous value for write acks.
  - Total latency from grant edge to rsp_valid = MEM_LAT+1 cycles.
  - Responses return in grant order.
- ena=0 mid-operation: no new grants; in-flight responses still drain.
- Simultaneous events:
  - A master may issue a new request in the same cycle its previous response arrives.
  - Requests from the same master may be in flight back-to-back.
- Width rules:
  - No address translation; mem_addr = req_addr unchanged (byte address).
  - Owner id is clog2(N_MASTERS) bits, minimum 1.
- N_MASTERS=1 degenerates to a registered pass-through with req_ready = req_valid & ena.

Decomposition:
- Package soc_mem_pkg:
  - Constants MAX_MASTERS=8 and MAX_MEM_LAT=4.
  - Function clog2.
  - Typedef for the tracking entry {valid, owner, is_write}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Reused later by the interrupt controller.

Test Plan:
- Reset: hold reset=0 with all req_valid=1 -> all outputs 0, no req_ready. Release -> master 0 granted first.
- Round-robin: N=2, MEM_LAT=1, both masters valid continuously -> grants alternate 0,1,0,1. Each rsp_valid arrives 2 cycles after its grant, rsp_rdata matches the preloaded memory words.
- Byte-enable write: master 1 writes 0xDEADBEEF with be=0b0011 to 0x40 over preloaded 0x11223344; then master 1 reads 0x40 -> mem_be=0b0011 on the write; the read returns 0x1122BEEF; a write ack rsp_valid is seen.
- Latency: MEM_LAT=3, N=4, masters 1 and 3 issue back-to-back reads -> responses arrive at +4 cycles, in order, with correct one-hot owner.
- ena toggling: two reads in flight, then ena=0 -> both responses still arrive; no req_ready while ena=0; arbitration resumes from the saved pointer when ena=1.
- Reset mid-flight: MEM_LAT=2, accept a read, then assert reset the next cycle -> no rsp_valid is ever produced for that read; pointer returns to 0.

Source files
------------

// File: rtl/soc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soc_mem_pkg
// Brief    : Shared constants, helpers and types for the unified memory port
// Revision : 1.0 - initial release
// ============================================================================
package soc_mem_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int MAX_MEM_LAT = 4;

    // Ceiling log2; returns 0 for value <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Owner field is sized for the largest supported master count
    localparam int c_OWNER_W = clog2(MAX_MASTERS);

    // One entry of the response-tracking pipeline
    typedef struct packed {
        logic                 valid;
        logic [c_OWNER_W-1:0] owner;
        logic                 is_write;
    } trk_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; grants the first requester at
//            or after the pointer, searching upward with wrap-around
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    input  wire logic             i_en,
    output logic      [N-1:0]     o_gnt,
    output logic      [IDX_W-1:0] o_gnt_idx,
    output logic                  o_any_gnt
);

    logic w_found;

    // Two passes: first the masters at or above the pointer, then wrap to the bottom
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (i_en && !w_found && i_req[j] && (j >= int'(i_ptr))) begin
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDX_W'(j);
                w_found   = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (i_en && !w_found && i_req[j]) begin
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IDX_W'(j);
                w_found   = 1'b1;
            end
        end
        o_any_gnt = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/soc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_mem_arbiter
// Brief    : N-master round-robin front end for one synchronous memory with
//            registered command issue and in-order response tracking
// Revision : 1.0 - initial release
// ============================================================================
module soc_mem_arbiter
    import soc_mem_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1
) (
    input  wire logic                          clk,
    input  wire logic                          reset,
    input  wire logic                          ena,
    input  wire logic [N_MASTERS-1:0]          req_valid,
    output logic      [N_MASTERS-1:0]          req_ready,
    input  wire logic [N_MASTERS-1:0]          req_we,
    input  wire logic [N_MASTERS*ADDR_W-1:0]   req_addr,
    input  wire logic [N_MASTERS*DATA_W-1:0]   req_wdata,
    input  wire logic [N_MASTERS*DATA_W/8-1:0] req_be,
    output logic      [N_MASTERS-1:0]          rsp_valid,
    output logic      [DATA_W-1:0]             rsp_rdata,
    output logic                               mem_en,
    output logic                               mem_we,
    output logic      [DATA_W/8-1:0]           mem_be,
    output logic      [ADDR_W-1:0]             mem_addr,
    output logic      [DATA_W-1:0]             mem_wdata,
    input  wire logic [DATA_W-1:0]             mem_rdata
);

    localparam int c_ID_W = (N_MASTERS > 1) ? clog2(N_MASTERS) : 1;
    localparam int c_BE_W = DATA_W / 8;

    logic [c_ID_W-1:0]    r_ptr;
    logic [N_MASTERS-1:0] w_gnt;
    logic [c_ID_W-1:0]    w_gnt_idx;
    logic                 w_any_gnt;
    logic                 w_arb_en;

    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [c_BE_W-1:0]    w_sel_be;

    logic [c_OWNER_W-1:0] r_cmd_owner;
    trk_entry_t           r_trk [MEM_LAT];
    trk_entry_t           w_exit;
    logic [DATA_W-1:0]    r_rdata_hold;

    // No grants while in reset so nothing transfers that would then be lost
    assign w_arb_en = ena & reset;

    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (c_ID_W)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .i_en      (w_arb_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any_gnt (w_any_gnt)
    );

    assign req_ready = w_gnt;

    // One-hot mux of the winning master's command fields
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            if (w_gnt[j]) begin
                w_sel_we    = req_we[j];
                w_sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[j*DATA_W +: DATA_W];
                w_sel_be    = req_be[j*c_BE_W +: c_BE_W];
            end
        end
    end

    // Register the winning command toward memory and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr       <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_be      <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_cmd_owner <= '0;
        end else begin
            mem_en <= w_any_gnt;
            if (w_any_gnt) begin
                mem_we      <= w_sel_we;
                mem_be      <= w_sel_we ? w_sel_be : {c_BE_W{1'b1}};
                mem_addr    <= w_sel_addr;
                mem_wdata   <= w_sel_wdata;
                r_cmd_owner <= c_OWNER_W'(w_gnt_idx);
                r_ptr       <= (w_gnt_idx == c_ID_W'(N_MASTERS - 1)) ? '0 : w_gnt_idx + 1'b1;
            end else begin
                mem_we <= 1'b0;
                mem_be <= '0;
            end
        end
    end

    // Track each issued command until its memory data returns; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) r_trk[i] <= '0;
        end else begin
            r_trk[0] <= '{valid: mem_en, owner: r_cmd_owner, is_write: mem_we};
            for (int i = 1; i < MEM_LAT; i++) r_trk[i] <= r_trk[i-1];
        end
    end

    assign w_exit = r_trk[MEM_LAT-1];

    // Remember the last read data so write acks leave rsp_rdata unchanged
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata_hold <= '0;
        end else if (w_exit.valid && !w_exit.is_write) begin
            r_rdata_hold <= mem_rdata;
        end
    end

    assign rsp_rdata = (w_exit.valid && !w_exit.is_write) ? mem_rdata : r_rdata_hold;

    // Decode the exiting owner into the one-hot response strobe
    always_comb begin
        rsp_valid = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            rsp_valid[j] = w_exit.valid && (w_exit.owner == c_OWNER_W'(j));
        end
    end

endmodule
`default_nettype wire
